sc_spi_xfer_seq: RTL
====================

// Module: sc_spi_xfer_seq
// PURPOSE
//  Transfer sequencer and TX/RX data buffer that sits directly upstream of the SPI protocol controller (sc_spi_spc).
//  Host side loads up to 16 x 32-bit TX words and issues one start command.
//  The block presents TXDATA by TXDPT, pulses SPISTART, captures RXDATA/RXDPT into an RX buffer and reports DONE.
//  It also owns CSEXTEND, for multi-frame chip-select retention.
// PARAMETERS
//  BUF_DEPTH   16   words per TX/RX buffer; fixed to 16 to match the 4-bit TXDPT/RXDPT pointers
//  START_TMO   4    max cycles from SPISTART to SPIBUSY=1 before a timeout error
// PORTS
//  SPICLK        in   1   single clock, rising edge only
//  SYSRSTB       in   1   synchronous, active-low reset
//  HTXWE         in   1   host TX buffer write enable
//  HTXWADDR      in   4   host TX buffer word address
//  HTXWDATA      in   32  host TX buffer write data
//  HRXRADDR      in   4   host RX buffer read address
//  HRXRDATA      out  32  host RX buffer read data, registered, 1-cycle latency
//  HSTART        in   1   host start pulse
//  HCSEXT        in   1   sampled with HSTART: keep CS asserted after this frame
//  HCSREL        in   1   host pulse: release an extended CS (accepted only when idle)
//  HBUSY         out  1   sequencer not in IDLE
//  HDONE         out  1   1-cycle pulse: frame finished and RX drained
//  HERR          out  3   sticky {timeout, tx_write_while_busy, start_while_busy}; cleared by HSTART accepted
//  SPISTART      out  1   to spc
//  SPIBUSY       in   1   from spc
//  CSEXTEND      out  1   to spc
//  TXDPT         in   4   from spc: TX word pointer
//  TXDATA        out  32  to spc: tx_buf[TXDPT], combinational read
//  RXDATA        in   32  from spc
//  RXVALID       in   1   from spc: RXDATA/RXDPT valid this cycle
//  RXDPT         in   4   from spc: RX word pointer
// BEHAVIOUR
//  Reset (SYSRSTB=0 at posedge): state=IDLE; all outputs are 0 (HRXRDATA, HERR, CSEXTEND included).
//   Buffer contents are not reset.
//   Reset mid-transfer: SPISTART and CSEXTEND are low the next cycle and no HDONE is issued.
//  FSM states: IDLE, REQ, XFER, DRAIN, DONE.
//   IDLE : HSTART=1 -> latch HCSEXT into cs_ext, clear HERR, go REQ.
//          HCSREL=1 (and no HSTART) -> cs_ext<=0.
//          HSTART and HCSREL in the same cycle: HSTART wins.
//   REQ  : SPISTART=1. SPIBUSY=1 -> SPISTART=0 next cycle, go XFER.
//          START_TMO cycles without SPIBUSY -> HERR[2]=1, go IDLE, no HDONE.
//   XFER : wait for SPIBUSY=0, then go DRAIN.
//   DRAIN: 2 cycles, so late RXVALID beats land; then go DONE.
//   DONE : HDONE=1 for one cycle; go IDLE.
//  CSEXTEND = cs_ext, held across IDLE until HCSREL or the next HSTART with HCSEXT=0.
//  HBUSY = (state != IDLE).
//  TX buffer:
//   HTXWE in IDLE writes tx_buf[HTXWADDR] at the posedge.
//   HTXWE while HBUSY: write dropped, HERR[1]=1.
//  RX buffer:
//   RXVALID=1 writes rx_buf[RXDPT]<=RXDATA, in any state.
//   Same-cycle host read of the same address returns the old word (read-before-write).
//  HSTART while HBUSY: ignored, HERR[0]=1.
//  HERR bits are sticky; they are cleared only by an accepted HSTART.
//   The timeout bit is set after that clear.
//  Latency: HSTART to SPISTART = 1 cycle. SPIBUSY fall to HDONE = 3 cycles.
// STRUCTURE
//  Shared include sc_spi_defs.vh: FSM state localparams, BUF_DEPTH, HERR bit indices.
//  Sub-module sc_spi_dpram: 16x32, 1 write port, 1 async and 1 registered read port.
//   Instantiated twice: TX buffer (async read by TXDPT), RX buffer (registered read by HRXRADDR).
// TESTING
//  1. Load tx_buf[0..1]=32'hA5A5_0001/0002, HSTART, spc model with DWIDTH=63 ->
//     TXDATA tracks TXDPT 1->0, SPISTART 1 cycle after HSTART, HDONE 3 cycles after SPIBUSY falls.
//  2. spc model returns RXVALID at RXDPT=1 then 0 with 32'h1234_5678/9ABC_DEF0 ->
//     host reads addr1 = 32'h1234_5678 and addr0 = 32'h9ABC_DEF0, each after 1 cycle.
//  3. SPIBUSY held 0 after HSTART -> SPISTART for exactly 4 cycles, HERR=3'b100, no HDONE, HBUSY=0.
//  4. HSTART+HCSEXT=1 -> CSEXTEND=1 after HDONE. HCSREL -> CSEXTEND=0 next cycle.
//     HSTART+HCSREL in the same cycle -> start accepted, CSEXTEND=HCSEXT.
//  5. HTXWE and HSTART during XFER -> tx_buf unchanged, HERR=3'b011, the frame still completes with HDONE.
//  6. SYSRSTB=0 during XFER -> next cycle HBUSY/SPISTART/CSEXTEND/HERR=0; no HDONE afterwards.

Source files
------------

// File: rtl/sc_spi_xfer_seq_pkg.sv
// sc_spi_xfer_seq_pkg: shared types and constants for the SPI transfer sequencer
package sc_spi_xfer_seq_pkg;
  localparam int BUF_DEPTH = 16;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int START_TMO = 4;
  localparam logic [1:0] TMO_LAST = 2'(START_TMO - 1);
  localparam int HERR_TMO = 2;
  localparam int HERR_TXWB = 1;
  localparam int HERR_STB = 0;
  typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_XFER, ST_DRAIN, ST_DONE} state_e;
endpackage

// File: rtl/sc_spi_xfer_seq_if.sv
// sc_spi_xfer_seq_if: host buffer/command bus and SPI controller handshake
interface sc_spi_xfer_seq_if;
  import sc_spi_xfer_seq_pkg::*;
  logic          htxwe;
  logic [AW-1:0] htxwaddr;
  logic [DW-1:0] htxwdata;
  logic [AW-1:0] hrxraddr;
  logic [DW-1:0] hrxrdata;
  logic          hstart;
  logic          hcsext;
  logic          hcsrel;
  logic          hbusy;
  logic          hdone;
  logic [2:0]    herr;
  logic          spistart;
  logic          spibusy;
  logic          csextend;
  logic [AW-1:0] txdpt;
  logic [DW-1:0] txdata;
  logic [DW-1:0] rxdata;
  logic          rxvalid;
  logic [AW-1:0] rxdpt;
  modport slave (
    input  htxwe, htxwaddr, htxwdata, hrxraddr, hstart, hcsext, hcsrel,
           spibusy, txdpt, rxdata, rxvalid, rxdpt,
    output hrxrdata, hbusy, hdone, herr, spistart, csextend, txdata
  );
  modport master (
    output htxwe, htxwaddr, htxwdata, hrxraddr, hstart, hcsext, hcsrel,
           spibusy, txdpt, rxdata, rxvalid, rxdpt,
    input  hrxrdata, hbusy, hdone, herr, spistart, csextend, txdata
  );
endinterface

// File: rtl/sc_spi_xfer_seq_dpram.sv
// sc_spi_xfer_seq_dpram: 16x32 word buffer, one write port, one read port (async or registered)
module sc_spi_xfer_seq_dpram
  import sc_spi_xfer_seq_pkg::*;
#(
  parameter bit REG_RD = 1'b0
) (
  input  logic          clk_i,
  input  logic          rstb_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [BUF_DEPTH];
  logic [DW-1:0] rd_q;
  // storage array, deliberately without reset so contents survive a reset
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  // registered read samples the pre-write word, giving read-before-write on a collision
  always_ff @(posedge clk_i) begin
    if (!rstb_i) rd_q <= '0;
    else rd_q <= mem_q[raddr_i];
  end
  assign rdata_o = REG_RD ? rd_q : mem_q[raddr_i];
endmodule

// File: rtl/sc_spi_xfer_seq.sv
// sc_spi_xfer_seq: frame sequencer with TX/RX buffers in front of the SPI protocol controller
module sc_spi_xfer_seq
  import sc_spi_xfer_seq_pkg::*;
(
  input logic            spiclk_i,
  input logic            sysrstb_i,
  sc_spi_xfer_seq_if.slave bus_if
);
  state_e     state_q, state_d;
  logic [1:0] tmo_q, tmo_d;
  logic       drain_q, drain_d;
  logic       cs_ext_q, cs_ext_d;
  logic [2:0] herr_q, herr_d;
  logic       busy;
  assign busy = state_q != ST_IDLE;
  // state and status registers
  always_ff @(posedge spiclk_i) begin
    if (!sysrstb_i) begin
      state_q  <= ST_IDLE;
      tmo_q    <= '0;
      drain_q  <= 1'b0;
      cs_ext_q <= 1'b0;
      herr_q   <= '0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      drain_q  <= drain_d;
      cs_ext_q <= cs_ext_d;
      herr_q   <= herr_d;
    end
  end
  // next state, start timeout, drain window, CS retention and sticky errors
  always_comb begin
    state_d  = state_q;
    tmo_d    = '0;
    drain_d  = 1'b0;
    cs_ext_d = cs_ext_q;
    herr_d   = herr_q;
    if (busy && bus_if.htxwe) herr_d[HERR_TXWB] = 1'b1;
    if (busy && bus_if.hstart) herr_d[HERR_STB] = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (bus_if.hstart) begin
          cs_ext_d = bus_if.hcsext;
          herr_d   = '0;
          state_d  = ST_REQ;
        end else if (bus_if.hcsrel) begin
          cs_ext_d = 1'b0;
        end
      end
      ST_REQ: begin
        if (bus_if.spibusy) begin
          state_d = ST_XFER;
        end else if (tmo_q == TMO_LAST) begin
          herr_d[HERR_TMO] = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 2'd1;
        end
      end
      ST_XFER: state_d = bus_if.spibusy ? ST_XFER : ST_DRAIN;
      ST_DRAIN: begin
        drain_d = !drain_q;
        state_d = drain_q ? ST_DONE : ST_DRAIN;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  assign bus_if.hbusy    = busy;
  assign bus_if.hdone    = state_q == ST_DONE;
  assign bus_if.spistart = state_q == ST_REQ;
  assign bus_if.csextend = cs_ext_q;
  assign bus_if.herr     = herr_q;
  sc_spi_xfer_seq_dpram #(.REG_RD(1'b0)) u_tx_buf (
    .clk_i   (spiclk_i),
    .rstb_i  (sysrstb_i),
    .we_i    (bus_if.htxwe && !busy),
    .waddr_i (bus_if.htxwaddr),
    .wdata_i (bus_if.htxwdata),
    .raddr_i (bus_if.txdpt),
    .rdata_o (bus_if.txdata)
  );
  sc_spi_xfer_seq_dpram #(.REG_RD(1'b1)) u_rx_buf (
    .clk_i   (spiclk_i),
    .rstb_i  (sysrstb_i),
    .we_i    (bus_if.rxvalid),
    .waddr_i (bus_if.rxdpt),
    .wdata_i (bus_if.rxdata),
    .raddr_i (bus_if.hrxraddr),
    .rdata_o (bus_if.hrxrdata)
  );
endmodule
